// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone slave adapter.
// Holds the FSM state encoding, bus widths and the data word returned on a
// backend timeout.
package wb_pkg;

  localparam int unsigned WB_DATA_W = 32;
  localparam int unsigned WB_SEL_W  = 4;

  localparam logic [WB_DATA_W-1:0] WB_TIMEOUT_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StReq     = 2'd1,
    StAck     = 2'd2,
    StRelease = 2'd3
  } state_t;

endpackage

// File: rtl/wb_slv_watchdog.sv
// Backend watchdog for the Wishbone slave adapter.
// Counts cycles spent in the request state and flags expiry.
// Ports:
//   clk_i, rst_i  clock, asynchronous active-high reset
//   run_i         high while the adapter is waiting on the backend
//   expired_o     high in the TIMEOUT_CYCLES-th consecutive run cycle
module wb_slv_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  output logic expired_o
);

  localparam int unsigned CntW = 16;
  // Count starts at 0 in the first run cycle, so expiry lands on cycle N.
  localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (run_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = run_i && (cnt_q == Limit);

endmodule

// File: rtl/wishbone_slave_adapter.sv
// Wishbone classic-cycle slave endpoint forwarding each transfer as a single
// req/ready backend request, returning a registered one-cycle ACK and then
// waiting for STB release before accepting another transfer.
// Optional feature macro: WB_SLV_TIMEOUT_EN adds a backend watchdog and the
// timeout_o port.
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   wb_*_i / wb_*_o         Wishbone slave side
//   mem_*_o / mem_*_i       backend request port
//   timeout_o               watchdog expiry pulse (only with WB_SLV_TIMEOUT_EN)
module wishbone_slave_adapter
  import wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter logic [31:0] ADDR_MASK      = 32'hFFFF_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [31:0]          wb_addr_i,
  input  logic [WB_DATA_W-1:0] wb_data_i,
  input  logic                 wb_we_i,
  input  logic [WB_SEL_W-1:0]  wb_sel_i,
  input  logic                 wb_stb_i,
  input  logic                 wb_cyc_i,
  output logic [WB_DATA_W-1:0] wb_data_o,
  output logic                 wb_ack_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [31:0]          mem_addr_o,
  output logic [WB_DATA_W-1:0] mem_wdata_o,
  output logic [WB_SEL_W-1:0]  mem_be_o,
  input  logic                 mem_ready_i,
  input  logic [WB_DATA_W-1:0] mem_rdata_i
`ifdef WB_SLV_TIMEOUT_EN
  ,
  output logic                 timeout_o
`endif
);

  state_t state_q, state_d;

  logic                 hit;
  logic                 start;
  logic                 aborting;
  logic                 expired;
  logic                 abort_q;
  logic [WB_DATA_W-1:0] rdata_q;
  logic                 we_q;
  logic [31:0]          addr_q;
  logic [WB_DATA_W-1:0] wdata_q;
  logic [WB_SEL_W-1:0]  be_q;

  assign hit      = ((wb_addr_i & ADDR_MASK) == BASE_ADDR);
  assign start    = (state_q == StIdle) && wb_cyc_i && wb_stb_i && hit;
  // Master gave up on this cycle: complete the backend side but never ACK.
  assign aborting = abort_q || !wb_cyc_i;

`ifdef WB_SLV_TIMEOUT_EN
  logic timeout_q;

  wb_slv_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .run_i    (state_q == StReq),
    .expired_o(expired)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      timeout_q <= 1'b0;
    end else begin
      // A ready in the expiry cycle takes priority over the timeout.
      timeout_q <= (state_q == StReq) && expired && !mem_ready_i;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign expired = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StReq;
      end
      StReq: begin
        if (mem_ready_i || expired) state_d = aborting ? StRelease : StAck;
      end
      StAck: begin
        state_d = StRelease;
      end
      StRelease: begin
        if (!wb_stb_i || !wb_cyc_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from the state register only
  always_comb begin
    wb_ack_o  = (state_q == StAck);
    mem_req_o = (state_q == StReq);
  end

  // Request capture, abort tracking and read-data return
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      abort_q <= 1'b0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      if (start) begin
        abort_q <= 1'b0;
        we_q    <= wb_we_i;
        addr_q  <= wb_addr_i;
        wdata_q <= wb_data_i;
        be_q    <= wb_sel_i;
      end else if ((state_q == StReq) && !wb_cyc_i) begin
        abort_q <= 1'b1;
      end
      if (state_q == StReq) begin
        if (mem_ready_i) begin
          rdata_q <= we_q ? '0 : mem_rdata_i;
        end else if (expired) begin
          rdata_q <= WB_TIMEOUT_DATA;
        end
      end
    end
  end

  assign wb_data_o   = rdata_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_be_o    = be_q;

endmodule

// File: tb/tb_wishbone_slave_adapter.sv
// Self-checking bench for wishbone_slave_adapter: table of single transfers
// driven through a master/backend model, plus hand-written abort, reset and
// (with WB_SLV_TIMEOUT_EN) watchdog sequences. Inputs change on the falling
// edge, outputs are sampled on the falling edge.
module tb_wishbone_slave_adapter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] wb_addr_i = '0;
  logic [31:0] wb_data_i = '0;
  logic        wb_we_i = 1'b0;
  logic [3:0]  wb_sel_i = '0;
  logic        wb_stb_i = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic [31:0] wb_data_o;
  logic        wb_ack_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_ready_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
`ifdef WB_SLV_TIMEOUT_EN
  logic        timeout_o;
`endif

  wishbone_slave_adapter #(
    .BASE_ADDR     (32'h0000_0000),
    .ADDR_MASK     (32'hFFFF_0000),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .wb_addr_i  (wb_addr_i),
    .wb_data_i  (wb_data_i),
    .wb_we_i    (wb_we_i),
    .wb_sel_i   (wb_sel_i),
    .wb_stb_i   (wb_stb_i),
    .wb_cyc_i   (wb_cyc_i),
    .wb_data_o  (wb_data_o),
    .wb_ack_o   (wb_ack_o),
    .mem_req_o  (mem_req_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_be_o   (mem_be_o),
    .mem_ready_i(mem_ready_i),
    .mem_rdata_i(mem_rdata_i)
`ifdef WB_SLV_TIMEOUT_EN
    ,
    .timeout_o  (timeout_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic [31:0] rdata;  // backend read data
    int          waits;  // backend wait cycles
    int          hold;   // cycles STB stays high after ACK
    logic        hit;    // expected decode result
  } vec_t;

  vec_t        vecs[7];
  logic [31:0] sb_q[$];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sb_chk(input string name, input logic [31:0] act);
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s: got %h expected <no pending transfer>", name, act);
    end else begin
      logic [31:0] exp;
      exp = sb_q.pop_front();
      if (act !== exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", name, act, exp);
      end
    end
  endtask

  // Runs one transfer starting at the current falling edge and returns at a
  // falling edge where the DUT can accept a new request.
  task automatic do_txn(input vec_t v);
    int reqc;
    int acked;
    wb_addr_i = v.addr;
    wb_data_i = v.wdata;
    wb_we_i   = v.we;
    wb_sel_i  = v.sel;
    wb_cyc_i  = 1'b1;
    wb_stb_i  = 1'b1;
    mem_rdata_i = v.rdata;
    if (!v.hit) begin
      for (int c = 1; c <= 20; c++) begin
        @(negedge clk_i);
        chk("miss_no_req", mem_req_o, 0);
        chk("miss_no_ack", wb_ack_o, 0);
      end
      wb_stb_i = 1'b0;
      wb_cyc_i = 1'b0;
      @(negedge clk_i);
      return;
    end
    sb_q.push_back(v.we ? 32'h0 : v.rdata);
    reqc  = 0;
    acked = 0;
    for (int c = 1; c <= 40 && acked == 0; c++) begin
      @(negedge clk_i);
      if (c == 1) chk("req_in_cycle1", mem_req_o, 1);
      if (mem_req_o) begin
        reqc++;
        chk("mem_addr", mem_addr_o, v.addr);
        chk("mem_we", mem_we_o, v.we);
        chk("mem_wdata", mem_wdata_o, v.wdata);
        chk("mem_be", mem_be_o, v.sel);
        mem_ready_i = (reqc == v.waits + 1);
      end else begin
        mem_ready_i = 1'b0;
      end
      if (wb_ack_o) begin
        acked = 1;
        chk("ack_cycle", c, v.waits + 2);
        sb_chk("ack_data", wb_data_o);
      end
    end
    chk("ack_seen", acked, 1);
    chk("req_cycles", reqc, v.waits + 1);
    mem_ready_i = 1'b0;
    if (v.hold == 0) begin
      wb_stb_i = 1'b0;
      wb_cyc_i = 1'b0;
      @(negedge clk_i);
      chk("ack_one_cycle", wb_ack_o, 0);
      chk("release_no_req", mem_req_o, 0);
      @(negedge clk_i);
    end else begin
      for (int h = 0; h < v.hold; h++) begin
        @(negedge clk_i);
        chk("hold_no_ack", wb_ack_o, 0);
        chk("hold_no_req", mem_req_o, 0);
      end
      wb_stb_i = 1'b0;
      wb_cyc_i = 1'b0;
      @(negedge clk_i);
      chk("hold_release_no_req", mem_req_o, 0);
    end
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{32'h0000_0010, 1'b0, 32'h0, 4'hF, 32'h1234_5678, 0, 0, 1'b1};
    vecs[1] = '{32'h0000_0020, 1'b1, 32'hCAFE_F00D, 4'b0011, 32'h5555_AAAA, 3, 0, 1'b1};
    vecs[2] = '{32'h0000_FFFC, 1'b0, 32'h0, 4'hF, 32'hA5A5_5A5A, 1, 3, 1'b1};
    vecs[3] = '{32'h0000_8000, 1'b1, 32'h1122_3344, 4'hF, 32'h0BAD_0BAD, 0, 0, 1'b1};
    vecs[4] = '{32'h0001_0000, 1'b0, 32'h0, 4'hF, 32'h7777_7777, 0, 0, 1'b0};
    vecs[5] = '{32'hFFFF_0010, 1'b1, 32'h9999_9999, 4'hF, 32'h0, 0, 0, 1'b0};
    vecs[6] = '{32'h0000_0000, 1'b0, 32'h0, 4'hF, 32'hDEAD_C0DE, 2, 1, 1'b1};

    // Reset state
    #2;
    chk("rst_ack", wb_ack_o, 0);
    chk("rst_req", mem_req_o, 0);
    chk("rst_data", wb_data_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_we", mem_we_o, 0);
    chk("rst_wdata", mem_wdata_o, 0);
    chk("rst_be", mem_be_o, 0);
`ifdef WB_SLV_TIMEOUT_EN
    chk("rst_timeout", timeout_o, 0);
`endif
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);

    for (int i = 0; i < 7; i++) begin
      do_txn(vecs[i]);
    end

    // Abort: CYC drops in REQ cycle 2, backend completes in REQ cycle 4.
    wb_addr_i = 32'h0000_0040;
    wb_we_i   = 1'b0;
    wb_sel_i  = 4'hF;
    wb_cyc_i  = 1'b1;
    wb_stb_i  = 1'b1;
    mem_rdata_i = 32'h0F0F_0F0F;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk_i);
      chk("abort_req", mem_req_o, (c <= 4) ? 1 : 0);
      chk("abort_no_ack", wb_ack_o, 0);
      if (c == 2) begin
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
      end
      mem_ready_i = (c == 4);
    end
    @(negedge clk_i);
    chk("abort_no_ack_c6", wb_ack_o, 0);
    // Back in IDLE by cycle 6: a new request must be accepted immediately.
    v = '{32'h0000_0044, 1'b0, 32'h0, 4'hF, 32'h3141_5926, 0, 0, 1'b1};
    do_txn(v);

`ifdef WB_SLV_TIMEOUT_EN
    // Silent backend: expiry after 8 REQ cycles, ACK carries the timeout word.
    wb_addr_i = 32'h0000_0080;
    wb_we_i   = 1'b0;
    wb_cyc_i  = 1'b1;
    wb_stb_i  = 1'b1;
    sb_q.push_back(32'hDEAD_BEEF);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk_i);
      chk("to_req", mem_req_o, (c <= 8) ? 1 : 0);
      chk("to_pulse", timeout_o, (c == 9) ? 1 : 0);
      chk("to_ack", wb_ack_o, (c == 9) ? 1 : 0);
      if (wb_ack_o) sb_chk("to_data", wb_data_o);
    end
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    @(negedge clk_i);
    chk("to_pulse_end", timeout_o, 0);
    @(negedge clk_i);
`endif

    // Asynchronous reset in the middle of REQ.
    wb_addr_i = 32'h0000_0100;
    wb_we_i   = 1'b1;
    wb_data_i = 32'h2468_ACE0;
    wb_cyc_i  = 1'b1;
    wb_stb_i  = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("pre_rst_req", mem_req_o, 1);
    #1 rst_i = 1'b1;
    #1;
    chk("async_rst_req", mem_req_o, 0);
    chk("async_rst_ack", wb_ack_o, 0);
    chk("async_rst_addr", mem_addr_o, 0);
    chk("async_rst_data", wb_data_o, 0);
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      chk("post_rst_no_ack", wb_ack_o, 0);
    end

    chk("scoreboard_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
